seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Sequential ALU with a valid/ready request side, a valid/ready result side,
// a 4-bit flag register {V,C,N,Z} and an iterative shift-add multiplier.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             flags_load,
  input  logic [3:0]       flags_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags_out
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SETC = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_PAS1 = 4'b0101;
  localparam logic [3:0] OP_PAS2 = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_ADC  = 4'b1001;
  localparam logic [3:0] OP_SHL  = 4'b1010;
  localparam logic [3:0] OP_SHR  = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [3:0] OP_CLRC = 4'b1101;

  typedef enum logic [1:0] {IDLE, MUL_RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   result_reg;
  logic [3:0]         flags_reg;          // {V, C, N, Z}
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [SHW-1:0]     cnt_reg;

  logic               accept;
  logic               mul_last;
  logic [SHW-1:0]     shamt;
  logic [WIDTH:0]     add_sum, sub_diff, shl_ext, shr_ext;
  logic [WIDTH-1:0]   alu_result;
  logic [3:0]         alu_flags;
  logic               upd_zn;
  logic [2*WIDTH-1:0] acc_next;
  logic               mul_hi_nz;

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;
  assign flags_out = flags_reg;
  assign accept    = in_valid & in_ready;
  assign shamt     = operand2[SHW-1:0];
  assign mul_last  = (cnt_reg == SHW'(WIDTH - 1));

  // State register; reset drops any operation in flight
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state: multiply goes through MUL_RUN, everything else straight to DONE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = (operation == OP_MUL) ? MUL_RUN : DONE;
      MUL_RUN: if (mul_last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Single-cycle ALU evaluated on the live inputs; only sampled at accept
  always_comb begin
    add_sum    = {1'b0, operand1} + {1'b0, operand2}
               + {{WIDTH{1'b0}}, (operation == OP_ADC) & flags_reg[2]};
    sub_diff   = {1'b0, operand1} - {1'b0, operand2};
    shl_ext    = {1'b0, operand1} << shamt;
    shr_ext    = {operand1, 1'b0} >> shamt;
    alu_result = '0;
    alu_flags  = flags_reg;
    upd_zn     = 1'b0;
    case (operation)
      OP_ADD, OP_ADC: begin
        alu_result   = add_sum[WIDTH-1:0];
        alu_flags[2] = add_sum[WIDTH];
        alu_flags[3] = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                       (add_sum[WIDTH-1] != operand1[WIDTH-1]);
        upd_zn       = 1'b1;
      end
      OP_SUB: begin
        alu_result   = sub_diff[WIDTH-1:0];
        alu_flags[2] = sub_diff[WIDTH];   // borrow out == op2 > op1
        alu_flags[3] = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                       (sub_diff[WIDTH-1] != operand1[WIDTH-1]);
        upd_zn       = 1'b1;
      end
      OP_AND:  begin alu_result = operand1 & operand2; upd_zn = 1'b1; end
      OP_OR:   begin alu_result = operand1 | operand2; upd_zn = 1'b1; end
      OP_NOT:  begin alu_result = ~operand1;           upd_zn = 1'b1; end
      OP_PAS1: alu_result = operand1;
      OP_PAS2: alu_result = operand2;
      OP_SETC: alu_flags[2] = 1'b1;
      OP_CLRC: alu_flags[2] = 1'b0;
      OP_SHL: begin
        alu_result = shl_ext[WIDTH-1:0];
        if (shamt != '0) alu_flags[2] = shl_ext[WIDTH];
        upd_zn = 1'b1;
      end
      OP_SHR: begin
        alu_result = shr_ext[WIDTH:1];
        if (shamt != '0) alu_flags[2] = shr_ext[0];
        upd_zn = 1'b1;
      end
      default: alu_result = '0;       // NOP and the unused opcodes
    endcase
    if (upd_zn) begin
      alu_flags[0] = ~|alu_result;
      alu_flags[1] = alu_result[WIDTH-1];
    end
  end

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
  always_comb begin
    acc_next  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    mul_hi_nz = |acc_next[2*WIDTH-1:WIDTH];
  end

  // Datapath: captures at accept, iterates the multiplier, commits result and flags
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      result_reg <= '0;
      flags_reg  <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (operation == OP_MUL) begin
              acc_reg    <= '0;
              mcand_reg  <= {{WIDTH{1'b0}}, operand1};
              mplier_reg <= operand2;
              cnt_reg    <= '0;
            end else begin
              result_reg <= alu_result;
              flags_reg  <= alu_flags;
            end
          end else if (flags_load) begin
            flags_reg <= flags_in;
          end
        end
        MUL_RUN: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + 1'b1;
          if (mul_last) begin
            result_reg <= acc_next[WIDTH-1:0];
            flags_reg  <= {mul_hi_nz, mul_hi_nz, acc_next[WIDTH-1],
                           ~|acc_next[WIDTH-1:0]};
          end
        end
        default: ;                    // DONE holds everything for the consumer
      endcase
    end
  end

endmodule
